spi_slave_rx_tx: RTL and testbench
==================================

Name: spi_slave_rx_tx

Overview:
- SPI peripheral (slave) end of the 16-bit SPI link; the counterpart of the on-chip SCLK-generating master.
- Accepts cs_bar/sclk/mosi from an external master and oversamples them on the system clock.
- Receive path: deserialises MOSI into a 16-bit word with a valid pulse.
- Transmit path: serialises a buffered 16-bit word onto MISO.
- SPI mode 3: sclk idles high, MISO updated on sclk falling edge, MOSI sampled on sclk rising edge, MSB first.

Parameters:
- DATA_WIDTH, 16, bits per frame.
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser (minimum 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset.
- cs_bar  input  1  chip select from external master, active low.
- sclk  input  1  SPI clock from external master.
- mosi  input  1  serial data from master.
- miso  output  1  serial data to master.
- miso_oe  output  1  MISO pad output enable; high while the synchronised cs_bar is low.
- tx_data  input  DATA_WIDTH  word to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  holding register empty; word accepted when tx_valid&tx_ready.
- rx_data  output  DATA_WIDTH  last complete received word.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- tx_underrun  output  1  one-cycle pulse: frame started with an empty holding register.
- frame_err  output  1  one-cycle pulse: cs_bar rose before DATA_WIDTH bits, or extra sclk edges occurred.

Behaviour:
- Reset:
  - Outputs: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_err=0.
  - Internal: state IDLE, bit counters 0, synchronisers preset to idle levels (cs_bar=1, sclk=1, mosi=0).
  - Reset asserted mid-frame aborts the frame with no pulses.
- Inputs: cs_bar, sclk and mosi each pass through SYNC_STAGES flops. Edges are detected from the last two synchronised sclk samples.
- Timing constraint: sclk high and low times must each be at least 3 clk periods (sclk ≤ clk/6).
- Holding register: loaded on tx_valid&tx_ready; tx_ready then falls. tx_ready rises again on the cycle the word is copied into the shift register.
- State IDLE → SHIFT on synchronised cs_bar falling edge, same cycle:
  - Shift register ← holding register if full; otherwise ← 0 and tx_underrun pulses.
  - Bit counters cleared; miso=0.
- State SHIFT:
  - sclk falling edge, tx_cnt<DATA_WIDTH: miso ← shift[DATA_WIDTH-1-tx_cnt]; tx_cnt+1.
  - sclk rising edge, rx_cnt<DATA_WIDTH: rx_shift ← {rx_shift[DATA_WIDTH-2:0], mosi}; rx_cnt+1.
  - When rx_cnt reaches DATA_WIDTH: rx_data ← assembled word, rx_valid pulses one cycle after the final rising edge, state → DONE.
  - Synchronised cs_bar high before rx_cnt=DATA_WIDTH: frame_err pulse, rx_data unchanged, state → IDLE.
- State DONE:
  - Further sclk edges are ignored; the first extra rising edge pulses frame_err once per frame.
  - Synchronised cs_bar high → IDLE, miso ← 0.
- rx_valid and frame_err are never asserted in the same cycle.
- Simultaneous tx_valid and frame start: the new word goes to the holding register and is sent in the next frame. The current frame uses the previous holding contents, or underruns.
- Back-to-back frames: cs_bar high for at least SYNC_STAGES+1 clk cycles is required between frames.

Optional Feature:
- Macro SPI_SLAVE_LOOPBACK_EN.
- When defined:
  - Adds input port loopback (1 bit).
  - With loopback=1 at frame start, the shift register loads the previous rx_data instead of the holding register.
  - The holding register and tx_ready are untouched, and tx_underrun is suppressed.
- When undefined: port absent; transmit data always comes from the holding register.

Test Plan:
- Load tx_data=0xA5C3, then a 16-bit mode-3 frame at clk/8 with mosi=0x1234 → miso shows 0xA5C3 MSB-first on falling edges; rx_data=0x1234; one rx_valid pulse; tx_ready returns to 1.
- Frame with no word loaded, mosi=0xFFFF → miso all zero, tx_underrun pulses once at frame start, rx_data=0xFFFF.
- cs_bar raised after 9 sclk cycles → frame_err pulse, no rx_valid, rx_data retains its prior value. The next full frame with 0x00FF → rx_data=0x00FF.
- 17 sclk cycles in one frame with mosi=0xBEEF → rx_data=0xBEEF, rx_valid once, frame_err once on the 17th rising edge.
- Reset pulsed after 8 bits → all outputs at reset values, tx_ready=1. A fresh frame with 0x5A5A is received correctly.
- With SPI_SLAVE_LOOPBACK_EN defined: frame 1 mosi=0xC0DE, loopback=1; frame 2 → miso returns 0xC0DE and tx_underrun stays low.

Source files
------------

// File: rtl/spi_slave_rx_tx.sv
// SPI mode-3 peripheral: oversampled cs_bar/sclk/mosi, 16-bit MSB-first receive and transmit paths.
// Optional define SPI_SLAVE_LOOPBACK_EN adds a loopback input that echoes the previous rx_data on MISO.
module spi_slave_rx_tx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs_bar,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
`ifdef SPI_SLAVE_LOOPBACK_EN
    input  logic                  loopback,
`endif
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic                    cs_prev_q, sclk_prev_q;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]        tx_cnt_q, tx_cnt_d;
    logic [CNT_W-1:0]        rx_cnt_q, rx_cnt_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    underrun_q, underrun_d;
    logic                    frame_err_q, frame_err_d;
    logic                    extra_seen_q, extra_seen_d;
    logic                    miso_q, miso_d;

    logic cs_s, sclk_s, mosi_s;
    logic cs_fall, sclk_rise, sclk_fall;
    logic tx_accept, use_loopback;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign cs_fall   = cs_prev_q & ~cs_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;

`ifdef SPI_SLAVE_LOOPBACK_EN
    assign use_loopback = loopback;
`else
    assign use_loopback = 1'b0;
`endif

    assign tx_accept = tx_valid & ~hold_full_q;

    assign miso        = miso_q;
    assign miso_oe     = ~cs_s;
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign frame_err   = frame_err_q;

    // Synchronisers start at bus-idle levels so reset release never looks like a frame start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '1;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_bar};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
        state_d      = state_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        tx_shift_d   = tx_shift_q;
        rx_shift_d   = rx_shift_q;
        tx_cnt_d     = tx_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        underrun_d   = 1'b0;
        frame_err_d  = 1'b0;
        extra_seen_d = extra_seen_q;
        miso_d       = miso_q;

        if (tx_accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d      = ST_SHIFT;
                    tx_cnt_d     = '0;
                    rx_cnt_d     = '0;
                    rx_shift_d   = '0;
                    extra_seen_d = 1'b0;
                    miso_d       = 1'b0;
                    // A word accepted this same cycle stays in the holding register for the next frame.
                    if (use_loopback) begin
                        tx_shift_d = rx_data_q;
                    end else if (hold_full_q) begin
                        tx_shift_d  = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        tx_shift_d = '0;
                        underrun_d = 1'b1;
                    end
                end
            end

            ST_SHIFT: begin
                if (cs_s) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                end else begin
                    if (sclk_fall && tx_cnt_q < CNT_W'(DATA_WIDTH)) begin
                        miso_d     = tx_shift_q[DATA_WIDTH-1];
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                        tx_cnt_d   = tx_cnt_q + CNT_W'(1);
                    end
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                        rx_cnt_d   = rx_cnt_q + CNT_W'(1);
                        if (rx_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                            rx_data_d  = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                            rx_valid_d = 1'b1;
                            state_d    = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end else if (sclk_rise && !extra_seen_q) begin
                    frame_err_d  = 1'b1;
                    extra_seen_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: data registers are reset too, so rx_data and the shift paths are defined from the first cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            tx_shift_q   <= '0;
            rx_shift_q   <= '0;
            tx_cnt_q     <= '0;
            rx_cnt_q     <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            underrun_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            extra_seen_q <= 1'b0;
            miso_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            tx_shift_q   <= tx_shift_d;
            rx_shift_q   <= rx_shift_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            underrun_q   <= underrun_d;
            frame_err_q  <= frame_err_d;
            extra_seen_q <= extra_seen_d;
            miso_q       <= miso_d;
        end
    end

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Self-checking bench for spi_slave_rx_tx: mode-3 master model with rx and miso scoreboards.
// Define SPI_SLAVE_LOOPBACK_EN to also exercise the loopback port.
module tb_spi_slave_rx_tx;

    localparam int DW   = 16;
    localparam int HALF = 4;  // sclk half period in clk cycles (sclk = clk/8)

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cs_bar, sclk, mosi;
    logic          miso, miso_oe;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          loopback;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid, tx_underrun, frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cnt_rxv  = 0;
    int cnt_und  = 0;
    int cnt_ferr = 0;

    logic [DW-1:0] exp_rx_q[$];
    logic [DW-1:0] exp_miso_q[$];

    always #5 clk = ~clk;

    spi_slave_rx_tx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .cs_bar     (cs_bar),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
`ifdef SPI_SLAVE_LOOPBACK_EN
        .loopback   (loopback),
`endif
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_underrun(tx_underrun),
        .frame_err  (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Output monitor: pulse counters plus the rx scoreboard.
    always @(negedge clk) begin
        if (rx_valid) begin
            cnt_rxv++;
            if (exp_rx_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
            else check("rx_data_sb", rx_data, exp_rx_q.pop_front());
        end
        if (tx_underrun) cnt_und++;
        if (frame_err) cnt_ferr++;
        if (rx_valid && frame_err) check("rxv_ferr_same_cycle", 32'd1, 32'd0);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_word(input logic [DW-1:0] w);
        int t = 0;
        while (!tx_ready && t < 50) begin
            wait_clk(1);
            t++;
        end
        if (t >= 50) check("tx_ready_timeout", 32'd0, 32'd1);
        tx_data  = w;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        check("tx_ready_after_load", tx_ready, 1'b0);
    endtask

    // Mode-3 master: mosi changes on falling sclk, miso sampled just before rising sclk.
    task automatic frame(input logic [DW-1:0] mosi_word, input int ncyc, input logic [DW-1:0] exp_miso);
        logic [DW-1:0] got;
        got = '0;
        if (ncyc >= DW) exp_rx_q.push_back(mosi_word);
        exp_miso_q.push_back(exp_miso);
        cs_bar = 1'b0;
        wait_clk(HALF);
        check("miso_oe_in_frame", miso_oe, 1'b1);
        for (int i = 0; i < ncyc; i++) begin
            sclk = 1'b0;
            mosi = (i < DW) ? mosi_word[DW-1-i] : 1'b0;
            wait_clk(HALF);
            if (i < DW) got[DW-1-i] = miso;
            sclk = 1'b1;
            wait_clk(HALF);
        end
        wait_clk(HALF);
        cs_bar = 1'b1;
        wait_clk(6);
        if (ncyc >= DW) check("miso_word", got, exp_miso_q.pop_front());
        else void'(exp_miso_q.pop_front());
        check("miso_idle", {miso_oe, miso}, 2'b00);
    endtask

    int rxv0, und0, ferr0;

    task automatic snap();
        rxv0 = cnt_rxv; und0 = cnt_und; ferr0 = cnt_ferr;
    endtask

    initial begin
        rst_n = 1'b0; cs_bar = 1'b1; sclk = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0; loopback = 1'b0;
        wait_clk(3);
        check("rst_outputs", {miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_err}, 6'b001000);
        check("rst_rx_data", rx_data, 16'h0000);
        rst_n = 1'b1;
        wait_clk(3);

        // Loaded word out, 0x1234 in.
        snap();
        load_word(16'hA5C3);
        frame(16'h1234, 16, 16'hA5C3);
        check("t1_rx_data", rx_data, 16'h1234);
        check("t1_pulses", {8'(cnt_rxv - rxv0), 8'(cnt_und - und0), 8'(cnt_ferr - ferr0)}, 24'h010000);
        check("t1_tx_ready", tx_ready, 1'b1);

        // Underrun: nothing loaded.
        snap();
        frame(16'hFFFF, 16, 16'h0000);
        check("t2_rx_data", rx_data, 16'hFFFF);
        check("t2_pulses", {8'(cnt_rxv - rxv0), 8'(cnt_und - und0), 8'(cnt_ferr - ferr0)}, 24'h010100);

        // Short frame aborted after 9 sclk cycles.
        snap();
        frame(16'hAAAA, 9, 16'h0000);
        check("t3_rx_kept", rx_data, 16'hFFFF);
        check("t3_pulses", {8'(cnt_rxv - rxv0), 8'(cnt_ferr - ferr0)}, 16'h0001);
        frame(16'h00FF, 16, 16'h0000);
        check("t3_rx_next", rx_data, 16'h00FF);

        // 17 sclk cycles; second word offered while holding register full.
        snap();
        load_word(16'h1111);
        tx_data = 16'h2222;
        tx_valid = 1'b1;
        frame(16'hBEEF, 17, 16'h1111);
        tx_valid = 1'b0;
        check("t4_rx_data", rx_data, 16'hBEEF);
        check("t4_pulses", {8'(cnt_rxv - rxv0), 8'(cnt_und - und0), 8'(cnt_ferr - ferr0)}, 24'h010001);
        check("t4_second_held", tx_ready, 1'b0);
        frame(16'h3C3C, 16, 16'h2222);
        check("t4_second_sent", tx_ready, 1'b1);

        // Reset mid-frame after 8 bits, with a word pending.
        load_word(16'h7777);
        snap();
        cs_bar = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 8; i++) begin
            sclk = 1'b0; mosi = i[0];
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
        end
        rst_n = 1'b0;
        wait_clk(2);
        check("t5_rst_outputs", {miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_err}, 6'b001000);
        check("t5_rst_rx_data", rx_data, 16'h0000);
        cs_bar = 1'b1;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(4);
        check("t5_no_pulses", {8'(cnt_rxv - rxv0), 8'(cnt_ferr - ferr0)}, 16'h0000);
        frame(16'h5A5A, 16, 16'h0000);
        check("t5_rx_fresh", rx_data, 16'h5A5A);

`ifdef SPI_SLAVE_LOOPBACK_EN
        snap();
        loopback = 1'b1;
        frame(16'hC0DE, 16, 16'h5A5A);
        frame(16'h0001, 16, 16'hC0DE);
        loopback = 1'b0;
        check("lb_no_underrun", 8'(cnt_und - und0), 8'h00);
        check("lb_tx_ready", tx_ready, 1'b1);
`endif

        wait_clk(10);
        check("rx_sb_drained", exp_rx_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
